lc3_controller: RTL

- Multicycle control FSM for the LC-3 core.
- Sequences fetch, decode and execute for each instruction.
- Drives datapath register loads, the four bus tri-state enables (en_pc, en_marmux, en_mdr, en_alu), mux selects and the memory write strobe memwe.
- Sits directly upstream of the datapath and memory. Its outputs are what the core's protocol checker monitors: one bus driver at a time, memwe only in stores and only for one cycle, condition codes loaded only by ADD/AND/NOT/LD/LDR/LDI.

---
 rtl/lc3_controller.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_controller.sv
// Multicycle fetch/decode/execute control FSM for the LC-3 core.
// Moore outputs decoded from state and ir; memory states dwell 1+MEM_WAIT cycles.
module lc3_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic        p_flag,
  output logic        ld_pc,
  output logic        ld_ir,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        en_pc,
  output logic        en_marmux,
  output logic        en_mdr,
  output logic        en_alu,
  output logic        memwe,
  output logic [1:0]  sel_pcmux,
  output logic        sel_addr1,
  output logic [1:0]  sel_addr2,
  output logic        sel_marmux,
  output logic        sel_sr1,
  output logic        sel_dr,
  output logic        sel_mdr,
  output logic [1:0]  alu_k,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [4:0]  state
);

  localparam logic [3:0] OpBr   = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpLd   = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpJsr  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpLdr  = 4'h6;
  localparam logic [3:0] OpStr  = 4'h7;
  localparam logic [3:0] OpRti  = 4'h8;
  localparam logic [3:0] OpNot  = 4'h9;
  localparam logic [3:0] OpLdi  = 4'hA;
  localparam logic [3:0] OpSti  = 4'hB;
  localparam logic [3:0] OpJmp  = 4'hC;
  localparam logic [3:0] OpIoe  = 4'hD;
  localparam logic [3:0] OpLea  = 4'hE;
  localparam logic [3:0] OpTrap = 4'hF;

  localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

  typedef enum logic [4:0] {
    StFetch0 = 5'd0,
    StFetch1 = 5'd1,
    StFetch2 = 5'd2,
    StDecode = 5'd3,
    StAlu    = 5'd4,
    StBr     = 5'd5,
    StJmp    = 5'd6,
    StJsr0   = 5'd7,
    StJsr1   = 5'd8,
    StLea    = 5'd9,
    StAddr   = 5'd10,
    StRd     = 5'd11,
    StInd    = 5'd12,
    StRd2    = 5'd13,
    StWb     = 5'd14,
    StMdrSr  = 5'd15,
    StStore  = 5'd16
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  logic [3:0] opcode;
  logic       mem_state;
  logic       mem_last;
  logic       br_taken;
  logic       is_illegal;
  logic       unused_ir_bits;

  assign opcode     = ir[15:12];
  assign mem_state  = (state_q == StFetch1) || (state_q == StRd) ||
                      (state_q == StRd2) || (state_q == StStore);
  assign mem_last   = (wait_q == WaitLast);
  assign br_taken   = (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);
  assign is_illegal = (opcode == OpRti) || (opcode == OpIoe) || (opcode == OpTrap);
  // Offsets and register fields are consumed by the datapath, not here.
  assign unused_ir_bits = ^ir[8:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch0;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = 3'd0;
    if (mem_state && !mem_last) begin
      wait_d = wait_q + 3'd1;
    end else begin
      case (state_q)
        StFetch0: state_d = StFetch1;
        StFetch1: state_d = StFetch2;
        StFetch2: state_d = StDecode;
        StDecode: begin
          case (opcode)
            OpAdd, OpAnd, OpNot:               state_d = StAlu;
            OpBr:                              state_d = StBr;
            OpJmp:                             state_d = StJmp;
            OpJsr:                             state_d = StJsr0;
            OpLea:                             state_d = StLea;
            OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti: state_d = StAddr;
            default:                           state_d = StFetch0;
          endcase
        end
        StJsr0:   state_d = StJsr1;
        StAddr:   state_d = (opcode == OpSt || opcode == OpStr) ? StMdrSr : StRd;
        StRd:     state_d = (opcode == OpLdi || opcode == OpSti) ? StInd : StWb;
        StInd:    state_d = StRd2;
        StRd2:    state_d = (opcode == OpSti) ? StMdrSr : StWb;
        StMdrSr:  state_d = StStore;
        default:  state_d = StFetch0;
      endcase
    end
  end

  always_comb begin
    ld_pc      = 1'b0;
    ld_ir      = 1'b0;
    ld_mar     = 1'b0;
    ld_mdr     = 1'b0;
    ld_reg     = 1'b0;
    ld_cc      = 1'b0;
    en_pc      = 1'b0;
    en_marmux  = 1'b0;
    en_mdr     = 1'b0;
    en_alu     = 1'b0;
    memwe      = 1'b0;
    sel_pcmux  = 2'b00;
    sel_addr1  = 1'b0;
    sel_addr2  = 2'b00;
    sel_marmux = 1'b0;
    sel_sr1    = 1'b0;
    sel_dr     = 1'b0;
    sel_mdr    = 1'b0;
    alu_k      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state      = 5'd0;
    // Reset overrides the decode so nothing leaks from an abandoned instruction.
    if (!reset) begin
      state = state_q;
      case (state_q)
        StFetch0: begin
          en_pc  = 1'b1;
          ld_mar = 1'b1;
          ld_pc  = 1'b1;
        end
        StFetch1, StRd, StRd2: begin
          ld_mdr  = mem_last;
          sel_mdr = mem_last;
        end
        StFetch2: begin
          en_mdr = 1'b1;
          ld_ir  = 1'b1;
        end
        StDecode: begin
          illegal_op = is_illegal;
          instr_done = is_illegal;
        end
        StAlu: begin
          en_alu     = 1'b1;
          ld_reg     = 1'b1;
          ld_cc      = 1'b1;
          instr_done = 1'b1;
          case (opcode)
            OpAnd:   alu_k = 2'b01;
            OpNot:   alu_k = 2'b10;
            default: alu_k = 2'b00;
          endcase
        end
        StBr: begin
          instr_done = 1'b1;
          if (br_taken) begin
            ld_pc     = 1'b1;
            sel_pcmux = 2'b10;
            sel_addr2 = 2'b10;
          end
        end
        StJmp: begin
          ld_pc      = 1'b1;
          sel_pcmux  = 2'b10;
          sel_addr1  = 1'b1;
          instr_done = 1'b1;
        end
        StJsr0: begin
          en_pc  = 1'b1;
          ld_reg = 1'b1;
          sel_dr = 1'b1;
        end
        StJsr1: begin
          // BaseR is read after R7 was written, so JSRR R7 uses the new link value.
          ld_pc      = 1'b1;
          sel_pcmux  = 2'b10;
          instr_done = 1'b1;
          if (ir[11]) begin
            sel_addr2 = 2'b11;
          end else begin
            sel_addr1 = 1'b1;
          end
        end
        StLea: begin
          en_marmux  = 1'b1;
          sel_marmux = 1'b1;
          sel_addr2  = 2'b10;
          ld_reg     = 1'b1;
          instr_done = 1'b1;
        end
        StAddr: begin
          en_marmux  = 1'b1;
          sel_marmux = 1'b1;
          ld_mar     = 1'b1;
          if (opcode == OpLdr || opcode == OpStr) begin
            sel_addr1 = 1'b1;
            sel_addr2 = 2'b01;
          end else begin
            sel_addr2 = 2'b10;
          end
        end
        StInd: begin
          en_mdr = 1'b1;
          ld_mar = 1'b1;
        end
        StWb: begin
          en_mdr     = 1'b1;
          ld_reg     = 1'b1;
          ld_cc      = 1'b1;
          instr_done = 1'b1;
        end
        StMdrSr: begin
          en_alu  = 1'b1;
          alu_k   = 2'b11;
          sel_sr1 = 1'b1;
          ld_mdr  = 1'b1;
        end
        StStore: begin
          memwe      = mem_last;
          instr_done = mem_last;
        end
        default: ;
      endcase
    end
  end

endmodule
